// File: rtl/hash_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// hash_mem_arbiter_if
//
// Bundles the per-core request/grant handshake and the single-port hash
// memory bus that the arbiter sits between.
//
//   req, we          per-core request / write enable          (cores -> arbiter)
//   addr, wdata      per-core address / write data, packed     (cores -> arbiter)
//   gnt, rvalid      one-hot grant / per-core read strobe      (arbiter -> cores)
//   rdata            read data broadcast to every core         (arbiter -> cores)
//   mem_we, memory_addr, memory_write_data                     (arbiter -> memory)
//   memory_read_data memory read data, 1-cycle latency         (memory -> arbiter)
//
// modport slave  : the arbiter's view.
// modport master : the view of the cores and the memory together.
// -----------------------------------------------------------------------------
interface hash_mem_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [NUM_REQ*16-1:0] addr;
    logic [NUM_REQ*32-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    logic [31:0]           rdata;
    logic                  mem_we;
    logic [15:0]           memory_addr;
    logic [31:0]           memory_write_data;
    logic [31:0]           memory_read_data;

    modport slave (
        input  req, we, addr, wdata, memory_read_data,
        output gnt, rvalid, rdata, mem_we, memory_addr, memory_write_data
    );

    modport master (
        output req, we, addr, wdata, memory_read_data,
        input  gnt, rvalid, rdata, mem_we, memory_addr, memory_write_data
    );
endinterface

// File: rtl/hash_mem_arbiter.sv
// -----------------------------------------------------------------------------
// hash_mem_arbiter
//
// Shares one single-port hash memory between NUM_REQ hashing cores. One core
// owns the memory at a time; ownership rotates round-robin, and a burst limit
// forces rotation when a streaming owner has made MAX_BURST accesses while
// other cores are waiting.
//
// Ports:
//   clk      system clock, forwarded unchanged as mem_clk
//   reset_n  synchronous, active-low reset
//   mem_clk  memory clock (= clk)
//   bus      hash_mem_arbiter_if.slave: core handshake plus memory port
// -----------------------------------------------------------------------------
module hash_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                mem_clk,
    hash_mem_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [7:0]         burst_q, burst_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic [NUM_REQ-1:0] own_mask;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               sel_found;
    logic               access;
    logic               others_req;
    logic               limit_hit;

    assign mem_clk    = clk;
    assign own_mask   = NUM_REQ'(1) << own_q;
    assign access     = (state_q == ST_OWN) && bus.req[own_q];
    assign others_req = |(bus.req & ~own_mask);
    // The access being counted now is the one that reaches the limit.
    assign limit_hit  = access && (({1'b0, burst_q} + 9'd1) >= 9'(MAX_BURST));

    // Round-robin pick: first requester at last+1, last+2, ... (mod NUM_REQ).
    // Scanning from the far end lets the nearest requester overwrite the
    // result. While a core owns, last_q == own_q, so the owner itself is the
    // final candidate and is only chosen when nobody else is asking.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Ownership FSM: next state, burst count and read-strobe generation.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        last_d   = last_q;
        burst_d  = burst_q;
        rvalid_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_OWN;
                    own_d   = sel_idx;
                    last_d  = sel_idx;
                    burst_d = '0;
                end
            end

            ST_OWN: begin
                if (!access) begin
                    // Release: hand over directly, no IDLE cycle in between.
                    burst_d = '0;
                    if (sel_found) begin
                        own_d  = sel_idx;
                        last_d = sel_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (!bus.we[own_q]) begin
                        rvalid_d = own_mask;
                    end
                    if (limit_hit && others_req) begin
                        // Preempt; the owner stays requesting and is requeued.
                        own_d   = sel_idx;
                        last_d  = sel_idx;
                        burst_d = '0;
                    end else if (limit_hit) begin
                        burst_d = 8'(MAX_BURST);
                    end else begin
                        burst_d = burst_q + 8'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        gnt_d = (state_d == ST_OWN) ? (NUM_REQ'(1) << own_d) : '0;
    end

    // Memory port: driven only while the owner is actually accessing.
    always_comb begin
        bus.mem_we            = 1'b0;
        bus.memory_addr       = '0;
        bus.memory_write_data = '0;
        if (access) begin
            bus.mem_we            = bus.we[own_q];
            bus.memory_addr       = bus.addr[own_q*16 +: 16];
            bus.memory_write_data = bus.wdata[own_q*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            own_q    <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            burst_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = bus.memory_read_data;
endmodule

// File: doc/hash_mem_arbiter.md
# hash_mem_arbiter

Shares the single-port hash memory (header words in, digest words out) between `NUM_REQ` hashing cores, so several nonce engines can run against one memory. Each core presents a request/grant handshake. The arbiter grants one owner at a time in round-robin order, muxes that owner's address, write-enable and write data onto the memory port, and returns read data with a per-requester valid strobe. A burst limit keeps a streaming core from starving the others.

## Interface
- `NUM_REQ`, 4, number of requesting cores (2..8)
- `MAX_BURST`, 16, accesses per tenure before forced rotation when others wait (1..255)
- `clk`  in  1  system clock; also drives `mem_clk`
- `reset_n`  in  1  one clock; reset is synchronous and active-low
- `req`  in  NUM_REQ  per-core request; held high for the whole tenure
- `we`  in  NUM_REQ  per-core write enable
- `addr`  in  NUM_REQ*16  per-core address, core i at bits [16i+15:16i]
- `wdata`  in  NUM_REQ*32  per-core write data, core i at bits [32i+31:32i]
- `gnt`  out  NUM_REQ  registered one-hot grant
- `rvalid`  out  NUM_REQ  read data valid for core i
- `rdata`  out  32  read data, broadcast to all cores; qualified by `rvalid`
- `mem_clk`  out  1  equals `clk`
- `mem_we`  out  1  memory write enable
- `memory_addr`  out  16  memory address
- `memory_write_data`  out  32  memory write data
- `memory_read_data`  in  32  memory read data, 1-cycle latency

## Operation
- States: IDLE (no owner) and OWN (owner index `own`, `gnt[own]` = 1).
- Access rule: core i performs a memory access in cycle C only if `gnt[i]` && `req[i]` in C.
- Memory port:
  - During an access: `memory_addr` = `addr[own]`, `memory_write_data` = `wdata[own]`, `mem_we` = `we[own]`.
  - Otherwise all three are 0.
  - These outputs are combinational from the registered owner and the inputs.
- Round-robin:
  - Pointer `last` holds the most recent owner.
  - The next owner is the first requester with `req` high, searching `last`+1, `last`+2, … modulo NUM_REQ.
  - `last` resets to NUM_REQ-1, so core 0 has priority first.
- IDLE → OWN: any `req` high in cycle C → owner selected in C, `gnt` asserted in C+1. Burst counter cleared.
- OWN release: `req[own]` low in cycle C.
  - No access occurs in C.
  - In C+1, `gnt` moves to the next requester selected in C, or all-zero with state IDLE if none.
- Burst counter:
  - 8 bits; increments on each access by the owner.
  - When it reaches MAX_BURST with the access in cycle C, and any other `req` is high in C, then `gnt` moves to the next requester in C+1. The owner's `req` may stay high; it is requeued.
  - If no other core requests, the counter saturates at MAX_BURST and the owner keeps the grant.
- Read return:
  - A read access by core i in cycle C sets `rvalid[i]` = 1 in C+1, with `rdata` = `memory_read_data` in C+1.
  - This holds even if `gnt[i]` has dropped in C+1.
  - `rdata` = `memory_read_data` in every cycle.
  - A write access produces no `rvalid`.
- Simultaneous events:
  - An owner releasing in the same cycle the burst limit is hit is treated as a release.
  - A new request arriving in the handover cycle is eligible if it is high in the selection cycle.
- Reset (synchronous): takes effect at the next edge, including mid-tenure.
  - `gnt` = 0, `rvalid` = 0, state IDLE, `last` = NUM_REQ-1, burst counter = 0.
  - Memory outputs = 0, since there is no owner.
  - A read issued in the reset cycle produces no `rvalid`.

## Timing
- Grant latency: 1 cycle from `req` high while IDLE.
- Read latency: data in the cycle after the access.
- Handover: exactly one dead memory cycle (the release cycle); no extra IDLE cycle when another core waits.
- Preemption: the next owner's first access occurs in the cycle after the limit access, with zero dead cycles.
- Reset values: `gnt` 0, `rvalid` 0, `mem_we` 0, `memory_addr` 0, `memory_write_data` 0. `rdata` follows memory.
- Throughput: one access per cycle during a tenure.

## Test plan
- Single read:
  - Stimulus: core 2 raises `req` with `we` = 0, `addr` = 16'h0005 at cycle 10.
  - Required response: `gnt` = 4'b0100 at 11, `memory_addr` = 5 at 11, `rvalid[2]` = 1 with `rdata` = memory word 5 at 12.
- Reset priority:
  - Stimulus: all four cores request in the first cycle after reset.
  - Required response: grant order 0, 1, 2, 3. Each core holds `req` for 3 accesses. One dead cycle between tenures.
- Write path:
  - Stimulus: core 1 writes 32'hDEADBEEF to 16'h0010.
  - Required response: `mem_we` = 1 for exactly one cycle with matching address and data. Readback gives 32'hDEADBEEF. No `rvalid` on the write.
- Burst preemption:
  - Stimulus: `MAX_BURST` = 4; core 0 streams reads; core 3 requests mid-tenure.
  - Required response: core 0 gets exactly 4 accesses, then `gnt` = 4'b1000 the next cycle. `rvalid[0]` still fires for the 4th read. Core 0 is regranted after core 3 releases.
- No contention:
  - Stimulus: core 1 streams 20 reads with `MAX_BURST` = 4.
  - Required response: grant held for all 20 accesses with no gaps.
- Reset mid-tenure:
  - Stimulus: `reset_n` low for one cycle while core 2 owns with a read issued.
  - Required response: next cycle `gnt` = 0 and `rvalid` = 0. Afterwards, core 0 wins over core 2 when both request.
